hazard_flush_ctrl: RTL and testbench
====================================

Name: hazard_flush_ctrl

Overview:
- Pipeline control block driving the clear/hold side of the ID/EX stage register.
- Consumes the ID/EX register outputs (destination, write-back enable, memory-read enable, branch) plus the source registers decoded in ID. Produces the Flush for ID/EX, the flush/hold for IF/ID, and a global freeze while data memory is not ready.
- Holds a small wait-state machine with a timeout, and saturating stall/flush event counters for performance monitoring.

Parameters:
- FORWARD_EN, 1, 1 = forwarding unit present, so only load-use stalls. 0 = stall on any EXE/MEM RAW match.
- CNT_W, 16, width of the performance counters.
- TIMEOUT, 255, maximum MEM_WAIT cycles before the sticky error is raised (range 1..255).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- id_src1  in  4  Rn of the instruction in ID
- id_src2  in  4  Rm/Rd-source of the instruction in ID
- id_two_src  in  1  ID instruction reads id_src2
- id_src1_used  in  1  ID instruction reads id_src1
- exe_dest  in  4  Dest_Out of ID/EX
- exe_wb_en  in  1  WB_EN_Out of ID/EX
- exe_mem_r_en  in  1  MEM_R_EN_Out of ID/EX
- exe_branch  in  1  B_Out of ID/EX (taken branch resolved in EXE)
- mem_dest  in  4  destination held in EX/MEM
- mem_wb_en  in  1  write-back enable held in EX/MEM
- mem_req  in  1  EX/MEM holds a load or store
- mem_ready  in  1  data memory completes the access this cycle
- cnt_clr  in  1  synchronous clear of both counters
- freeze_if_id  out  1  hold PC and IF/ID (ld = 0)
- flush_if_id  out  1  clear IF/ID
- flush_id_ex  out  1  Flush input of ID/EX
- freeze_all  out  1  hold every pipeline register
- mem_timeout  out  1  sticky error
- stall_cycles  out  CNT_W  cycles with freeze_if_id or freeze_all asserted
- flush_events  out  CNT_W  branch flushes taken

Behaviour:
- Reset (rst = 0, asynchronous): state = RUN, mem_timeout = 0, counters = 0, wait counter = 0. All control outputs are 0 while reset is held.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN -> MEM_WAIT when mem_req & !mem_ready.
  - MEM_WAIT -> RUN on the edge after mem_ready = 1.
  - MEM_WAIT -> ERROR when the wait counter reaches TIMEOUT.
  - ERROR is left only by reset.
- freeze_all is combinational:
  - In RUN or MEM_WAIT: mem_req & !mem_ready. It deasserts in the same cycle that mem_ready rises.
  - In ERROR: 1.
- Wait counter:
  - Increments each MEM_WAIT cycle.
  - Clears on entering RUN.
  - Reaching TIMEOUT sets mem_timeout = 1 on that edge.
- hazard (combinational):
  - m1 = id_src1_used & (src1 == dest).
  - m2 = id_two_src & (src2 == dest).
  - FORWARD_EN = 1: hazard = exe_wb_en & exe_mem_r_en & (m1 | m2) against exe_dest.
  - FORWARD_EN = 0: hazard = same match against exe_dest (with exe_wb_en, no exe_mem_r_en term) OR mem_wb_en & match against mem_dest.
- Priority, highest first:
  - freeze_all = 1: every other output is 0. A branch pending in ID/EX is held, not lost.
  - exe_branch: flush_if_id = 1, flush_id_ex = 1, freeze_if_id = 0. A coincident hazard is ignored because its instruction is squashed.
  - hazard: freeze_if_id = 1, flush_id_ex = 1 (one bubble per hazard cycle).
  - Otherwise all outputs are 0.
- Latency: all control outputs are same-cycle combinational from the inputs and the registered state.
- Counters:
  - stall_cycles increments on any cycle with freeze_if_id | freeze_all.
  - flush_events increments on any cycle with flush_if_id.
  - Both saturate at all-ones.
  - cnt_clr has priority over the increment.
  - Counters keep running in ERROR.

Decomposition:
- Shared package holds: state encoding (RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2), and the register-index width constant (4).
- One sub-module is natural: sat_counter (parameter W; inputs inc and clr; output count), instantiated twice.

Test Plan:
- Load-use: FORWARD_EN = 1, exe_dest = 3, exe_wb_en = 1, exe_mem_r_en = 1, id_src1 = 3, id_src1_used = 1 -> freeze_if_id = 1 and flush_id_ex = 1 for one cycle. stall_cycles = 1.
- No-forward RAW: FORWARD_EN = 0, mem_dest = 5, mem_wb_en = 1, id_src2 = 5, id_two_src = 1 -> stall asserted. Same stimulus with id_two_src = 0 -> no stall.
- Branch plus hazard in the same cycle: exe_branch = 1 with a load-use match -> flush_if_id = 1, flush_id_ex = 1, freeze_if_id = 0. flush_events = 1.
- Memory wait: mem_req = 1, mem_ready = 0 for 4 cycles, then 1 -> freeze_all high for 4 cycles and low in the ready cycle. The FSM returns to RUN. stall_cycles = 4.
- Timeout: TIMEOUT = 8, mem_ready held at 0 -> mem_timeout rises after 8 MEM_WAIT cycles. freeze_all stays 1 even after mem_ready = 1. Only rst clears it.
- Reset and saturation:
  - Drop rst mid-MEM_WAIT -> outputs go to 0 asynchronously and the state returns to RUN.
  - CNT_W = 4 with 20 stall cycles -> stall_cycles = 15.
  - cnt_clr = 1 -> counters read 0.

Source files
------------

// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard and flush controller.
package hazard_flush_ctrl_pkg;

    // Width of an architectural register index.
    localparam int REG_IDX_W = 4;

    // Wait-state machine encoding.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    // A source operand collides with a destination only when the operand is actually read.
    function automatic logic src_match(
        input logic                 used,
        input logic [REG_IDX_W-1:0] src,
        input logic [REG_IDX_W-1:0] dest
    );
        return used & (src == dest);
    endfunction

endpackage

// File: rtl/hazard_flush_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count events, stick at all-ones, clear on request.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Clear/hold control for the IF/ID and ID/EX stage registers, with a
// data-memory wait-state machine, a sticky timeout and stall/flush counters.
module hazard_flush_ctrl
    import hazard_flush_ctrl_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [REG_IDX_W-1:0] i_id_src1,
    input  logic [REG_IDX_W-1:0] i_id_src2,
    input  logic                 i_id_two_src,
    input  logic                 i_id_src1_used,
    input  logic [REG_IDX_W-1:0] i_exe_dest,
    input  logic                 i_exe_wb_en,
    input  logic                 i_exe_mem_r_en,
    input  logic                 i_exe_branch,
    input  logic [REG_IDX_W-1:0] i_mem_dest,
    input  logic                 i_mem_wb_en,
    input  logic                 i_mem_req,
    input  logic                 i_mem_ready,
    input  logic                 i_cnt_clr,
    output logic                 o_freeze_if_id,
    output logic                 o_flush_if_id,
    output logic                 o_flush_id_ex,
    output logic                 o_freeze_all,
    output logic                 o_mem_timeout,
    output logic [CNT_W-1:0]     o_stall_cycles,
    output logic [CNT_W-1:0]     o_flush_events
);

    // Value of the wait counter on the cycle whose edge makes it reach TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_mem_timeout;

    logic w_exe_match;
    logic w_mem_match;
    logic w_hazard;
    logic w_mem_stall;
    logic w_freeze_if_id;
    logic w_flush_if_id;
    logic w_flush_id_ex;
    logic w_freeze_all;

    assign w_exe_match = src_match(i_id_src1_used, i_id_src1, i_exe_dest)
                       | src_match(i_id_two_src,   i_id_src2, i_exe_dest);
    assign w_mem_match = src_match(i_id_src1_used, i_id_src1, i_mem_dest)
                       | src_match(i_id_two_src,   i_id_src2, i_mem_dest);
    assign w_mem_stall = i_mem_req & ~i_mem_ready;

    // Wait-state machine: track outstanding memory accesses and latch a timeout.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_wait_cnt    <= 8'd0;
                    r_mem_timeout <= r_mem_timeout;
                    if (w_mem_stall) begin
                        r_state <= ST_MEM_WAIT;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_mem_ready) begin
                        r_state       <= ST_RUN;
                        r_wait_cnt    <= 8'd0;
                        r_mem_timeout <= r_mem_timeout;
                    end else if (r_wait_cnt == TIMEOUT_LAST) begin
                        r_state       <= ST_ERROR;
                        r_wait_cnt    <= r_wait_cnt + 8'd1;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_state       <= ST_MEM_WAIT;
                        r_wait_cnt    <= r_wait_cnt + 8'd1;
                        r_mem_timeout <= r_mem_timeout;
                    end
                end
                ST_ERROR: begin
                    r_state       <= ST_ERROR;
                    r_wait_cnt    <= r_wait_cnt;
                    r_mem_timeout <= 1'b1;
                end
                default: begin
                    // An unencodable state is treated as a fault and parked in ERROR.
                    r_state       <= ST_ERROR;
                    r_wait_cnt    <= r_wait_cnt;
                    r_mem_timeout <= 1'b1;
                end
            endcase
        end
    end

    // Read-after-write detection; without forwarding every in-flight producer stalls.
    always_comb begin
        w_hazard = 1'b0;
        if (FORWARD_EN) begin
            w_hazard = i_exe_wb_en & i_exe_mem_r_en & w_exe_match;
        end else begin
            w_hazard = (i_exe_wb_en & w_exe_match) | (i_mem_wb_en & w_mem_match);
        end
    end

    // Prioritised control: memory freeze, then branch squash, then hazard bubble.
    always_comb begin
        w_freeze_if_id = 1'b0;
        w_flush_if_id  = 1'b0;
        w_flush_id_ex  = 1'b0;
        w_freeze_all   = 1'b0;
        if (!i_rst) begin
            w_freeze_all = 1'b0;
        end else if ((r_state == ST_ERROR) || w_mem_stall) begin
            // Everything holds, including a branch waiting in ID/EX.
            w_freeze_all = 1'b1;
        end else if (i_exe_branch) begin
            // The hazarding instruction in ID is squashed, so no stall is needed.
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
        end else if (w_hazard) begin
            w_freeze_if_id = 1'b1;
            w_flush_id_ex  = 1'b1;
        end else begin
            w_freeze_all = 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_freeze_if_id | w_freeze_all),
        .i_clr   (i_cnt_clr),
        .o_count (o_stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_flush_if_id),
        .i_clr   (i_cnt_clr),
        .o_count (o_flush_events)
    );

    assign o_freeze_if_id = w_freeze_if_id;
    assign o_flush_if_id  = w_flush_if_id;
    assign o_flush_id_ex  = w_flush_id_ex;
    assign o_freeze_all   = w_freeze_all;
    assign o_mem_timeout  = r_mem_timeout;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: two instances (forwarding / no forwarding,
// 16-bit / 4-bit counters) share one stimulus stream.
module tb_hazard_flush_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_two_src, id_src1_used, exe_wb_en, exe_mem_r_en, exe_branch;
    logic       mem_wb_en, mem_req, mem_ready, cnt_clr;

    logic        a_fif, a_flif, a_flie, a_fall, a_to;
    logic [15:0] a_stall, a_flush;
    logic        b_fif, b_flif, b_flie, b_fall, b_to;
    logic [3:0]  b_stall, b_flush;

    logic [3:0] a_ctrl, b_ctrl;
    assign a_ctrl = {a_fif, a_flif, a_flie, a_fall};
    assign b_ctrl = {b_fif, b_flif, b_flie, b_fall};

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    hazard_flush_ctrl #(.FORWARD_EN(1'b1), .CNT_W(16), .TIMEOUT(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_id_src1(id_src1), .i_id_src2(id_src2),
        .i_id_two_src(id_two_src), .i_id_src1_used(id_src1_used),
        .i_exe_dest(exe_dest), .i_exe_wb_en(exe_wb_en), .i_exe_mem_r_en(exe_mem_r_en),
        .i_exe_branch(exe_branch), .i_mem_dest(mem_dest), .i_mem_wb_en(mem_wb_en),
        .i_mem_req(mem_req), .i_mem_ready(mem_ready), .i_cnt_clr(cnt_clr),
        .o_freeze_if_id(a_fif), .o_flush_if_id(a_flif), .o_flush_id_ex(a_flie),
        .o_freeze_all(a_fall), .o_mem_timeout(a_to),
        .o_stall_cycles(a_stall), .o_flush_events(a_flush)
    );

    hazard_flush_ctrl #(.FORWARD_EN(1'b0), .CNT_W(4), .TIMEOUT(5)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_id_src1(id_src1), .i_id_src2(id_src2),
        .i_id_two_src(id_two_src), .i_id_src1_used(id_src1_used),
        .i_exe_dest(exe_dest), .i_exe_wb_en(exe_wb_en), .i_exe_mem_r_en(exe_mem_r_en),
        .i_exe_branch(exe_branch), .i_mem_dest(mem_dest), .i_mem_wb_en(mem_wb_en),
        .i_mem_req(mem_req), .i_mem_ready(mem_ready), .i_cnt_clr(cnt_clr),
        .o_freeze_if_id(b_fif), .o_flush_if_id(b_flif), .o_flush_id_ex(b_flie),
        .o_freeze_all(b_fall), .o_mem_timeout(b_to),
        .o_stall_cycles(b_stall), .o_flush_events(b_flush)
    );

    // ---------------- reference model (index 0 = dut_a, 1 = dut_b) ----------------
    bit fwd   [2] = '{1'b1, 1'b0};
    int tmo   [2] = '{8, 5};
    int cmax  [2] = '{65535, 15};
    bit m_wait[2];
    bit m_err [2];
    int m_waited[2];
    int m_stall [2];
    int m_flush [2];

    // Expected {freeze_if_id, flush_if_id, flush_id_ex, freeze_all}.
    function automatic logic [3:0] model_ctrl(input int k);
        bit rd_exe, rd_mem, haz;
        rd_exe = (id_src1_used && (id_src1 == exe_dest)) || (id_two_src && (id_src2 == exe_dest));
        rd_mem = (id_src1_used && (id_src1 == mem_dest)) || (id_two_src && (id_src2 == mem_dest));
        if (fwd[k]) haz = exe_wb_en && exe_mem_r_en && rd_exe;
        else        haz = (exe_wb_en && rd_exe) || (mem_wb_en && rd_mem);
        if (!rst)                              return 4'b0000;
        if (m_err[k] || (mem_req && !mem_ready)) return 4'b0001;
        if (exe_branch)                        return 4'b0110;
        if (haz)                               return 4'b1010;
        return 4'b0000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 1'b0; m_err[k] = 1'b0; m_waited[k] = 0;
            m_stall[k] = 0;   m_flush[k] = 0;
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] c;
            c = model_ctrl(k);
            if (cnt_clr) begin
                m_stall[k] = 0; m_flush[k] = 0;
            end else begin
                if (c[3] || c[0]) m_stall[k] = (m_stall[k] + 1 > cmax[k]) ? cmax[k] : m_stall[k] + 1;
                if (c[2])         m_flush[k] = (m_flush[k] + 1 > cmax[k]) ? cmax[k] : m_flush[k] + 1;
            end
            if (!m_err[k]) begin
                if (m_wait[k]) begin
                    if (mem_ready) begin
                        m_wait[k] = 1'b0; m_waited[k] = 0;
                    end else begin
                        m_waited[k]++;
                        if (m_waited[k] == tmo[k]) m_err[k] = 1'b1;
                    end
                end else if (mem_req && !mem_ready) begin
                    m_wait[k] = 1'b1;
                end
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " ctrl_a"},  32'(a_ctrl),  32'(model_ctrl(0)));
        chk({tag, " ctrl_b"},  32'(b_ctrl),  32'(model_ctrl(1)));
        chk({tag, " stall_a"}, 32'(a_stall), 32'(m_stall[0]));
        chk({tag, " stall_b"}, 32'(b_stall), 32'(m_stall[1]));
        chk({tag, " flush_a"}, 32'(a_flush), 32'(m_flush[0]));
        chk({tag, " flush_b"}, 32'(b_flush), 32'(m_flush[1]));
        chk({tag, " tmo_a"},   32'(a_to),    32'(m_err[0]));
        chk({tag, " tmo_b"},   32'(b_to),    32'(m_err[1]));
    endtask

    task automatic idle();
        id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0; id_src1_used = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_branch = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse starting away from the clock edge.
    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check_all("rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic set_load_use(input logic br);
        idle();
        id_src1 = 4'd3; id_src1_used = 1'b1;
        exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; exe_branch = br;
    endtask

    typedef struct {
        logic [3:0] s1, s2;
        logic       two, u1;
        logic [3:0] ed;
        logic       ewb, emr, br;
        logic [3:0] md;
        logic       mwb, mreq, mrdy;
        logic [3:0] ea, eb;
    } vec_t;

    vec_t tbl[11];

    initial begin
        rst = 1'b0;
        idle();
        model_reset();

        // {s1,s2,two,u1, ed,ewb,emr,br, md,mwb,mreq,mrdy, exp_a,exp_b}
        tbl[0]  = '{4'd3, 4'd0,  1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010};
        tbl[1]  = '{4'd3, 4'd0,  1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1010};
        tbl[2]  = '{4'd0, 4'd5,  1'b1, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1010};
        tbl[3]  = '{4'd0, 4'd5,  1'b0, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[4]  = '{4'd3, 4'd0,  1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110};
        tbl[5]  = '{4'd3, 4'd0,  1'b0, 1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[6]  = '{4'd3, 4'd9,  1'b1, 1'b0, 4'd3,  1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        tbl[7]  = '{4'd0, 4'd15, 1'b1, 1'b1, 4'd15, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1010, 4'b1010};
        tbl[8]  = '{4'd3, 4'd0,  1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001};
        tbl[9]  = '{4'd3, 4'd0,  1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'b0110, 4'b0110};
        tbl[10] = '{4'd3, 4'd0,  1'b0, 1'b1, 4'd3,  1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'b1010, 4'b1010};

        // Outputs quiet while reset is held, even with a stalling request present.
        #2;
        mem_req = 1'b1;
        #1;
        chk("reset ctrl_a", 32'(a_ctrl), 32'd0);
        chk("reset stall_a", 32'(a_stall), 32'd0);
        chk("reset tmo_a", 32'(a_to), 32'd0);
        idle();
        do_reset();

        // ---- table vectors, one per cycle ----
        for (int i = 0; i < 11; i++) begin
            idle();
            id_src1 = tbl[i].s1; id_src2 = tbl[i].s2; id_two_src = tbl[i].two; id_src1_used = tbl[i].u1;
            exe_dest = tbl[i].ed; exe_wb_en = tbl[i].ewb; exe_mem_r_en = tbl[i].emr; exe_branch = tbl[i].br;
            mem_dest = tbl[i].md; mem_wb_en = tbl[i].mwb; mem_req = tbl[i].mreq; mem_ready = tbl[i].mrdy;
            #1;
            chk($sformatf("tbl%0d ctrl_a", i), 32'(a_ctrl), 32'(tbl[i].ea));
            chk($sformatf("tbl%0d ctrl_b", i), 32'(b_ctrl), 32'(tbl[i].eb));
            tick();
        end

        // ---- load-use: one bubble, one stall cycle ----
        idle(); do_reset();
        set_load_use(1'b0);
        #1; chk("lu ctrl_a", 32'(a_ctrl), 32'b1010);
        tick(); idle();
        #1; chk("lu after ctrl_a", 32'(a_ctrl), 32'd0);
        chk("lu stall_a", 32'(a_stall), 32'd1);
        chk("lu stall_b", 32'(b_stall), 32'd1);

        // ---- branch with coincident load-use ----
        idle(); do_reset();
        set_load_use(1'b1);
        #1; chk("br ctrl_a", 32'(a_ctrl), 32'b0110);
        tick(); idle();
        #1; chk("br flush_a", 32'(a_flush), 32'd1);
        chk("br stall_a", 32'(a_stall), 32'd0);

        // ---- memory wait of 4 cycles with a branch held in ID/EX ----
        idle(); do_reset();
        exe_branch = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mw%0d freeze_a", i), 32'(a_fall), 32'd1);
            chk($sformatf("mw%0d flushif_a", i), 32'(a_flif), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("mw ready freeze_a", 32'(a_fall), 32'd0);
        chk("mw ready flushif_a", 32'(a_flif), 32'd1);
        tick(); idle();
        #1;
        chk("mw stall_a", 32'(a_stall), 32'd4);
        chk("mw stall_b", 32'(b_stall), 32'd4);
        chk("mw flush_a", 32'(a_flush), 32'd1);
        chk("mw tmo_a", 32'(a_to), 32'd0);

        // ---- timeout: A after 8 wait cycles, B after 5 ----
        idle(); do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk($sformatf("to e%0d tmo_a", e), 32'(a_to), (e >= 9) ? 32'd1 : 32'd0);
            chk($sformatf("to e%0d tmo_b", e), 32'(b_to), (e >= 6) ? 32'd1 : 32'd0);
        end
        mem_req = 1'b0; mem_ready = 1'b1; exe_branch = 1'b1;
        #1; chk("err freeze_a", 32'(a_ctrl), 32'b0001);
        chk("err freeze_b", 32'(b_ctrl), 32'b0001);
        tick();
        chk("err sticky_a", 32'(a_to), 32'd1);
        // Reset from ERROR asserts outputs low immediately.
        #2; rst = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        chk("err rst ctrl_a", 32'(a_ctrl), 32'd0);
        chk("err rst tmo_a", 32'(a_to), 32'd0);
        chk("err rst stall_a", 32'(a_stall), 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        idle(); exe_branch = 1'b1;
        #1; chk("post err run ctrl_a", 32'(a_ctrl), 32'b0110);
        tick();

        // ---- reset in the middle of MEM_WAIT clears the wait count ----
        idle(); do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        tick(); tick(); tick();
        #2; rst = 1'b0;
        #1; chk("mwrst ctrl_a", 32'(a_ctrl), 32'd0);
        chk("mwrst stall_a", 32'(a_stall), 32'd0);
        @(posedge clk); #1; rst = 1'b1;
        for (int e = 0; e < 8; e++) tick();
        chk("mwrst fresh tmo_a", 32'(a_to), 32'd0);

        // ---- saturation and clear ----
        idle(); do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int e = 0; e < 20; e++) tick();
        chk("sat stall_a", 32'(a_stall), 32'd20);
        chk("sat stall_b", 32'(b_stall), 32'd15);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr stall_a", 32'(a_stall), 32'd0);
        chk("clr stall_b", 32'(b_stall), 32'd0);
        tick();
        chk("err count stall_a", 32'(a_stall), 32'd1);

        // ---- randomized run against the reference model ----
        idle(); do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                idle();
                do_reset();
            end else begin
                id_src1      = 4'($urandom_range(0, 3));
                id_src2      = 4'($urandom_range(0, 3));
                exe_dest     = 4'($urandom_range(0, 3));
                mem_dest     = 4'($urandom_range(0, 3));
                id_two_src   = 1'($urandom_range(0, 1));
                id_src1_used = 1'($urandom_range(0, 1));
                exe_wb_en    = 1'($urandom_range(0, 1));
                exe_mem_r_en = 1'($urandom_range(0, 1));
                mem_wb_en    = 1'($urandom_range(0, 1));
                exe_branch   = ($urandom_range(0, 7) == 0);
                mem_req      = ($urandom_range(0, 3) == 0);
                mem_ready    = ($urandom_range(0, 1) == 0);
                cnt_clr      = ($urandom_range(0, 49) == 0);
                #1;
                check_all($sformatf("rnd%0d", n));
                model_edge();
                @(posedge clk);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
